// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data SRAM between the CPU MEM stage and the host port.
// CPU has default priority; a starvation counter bounds how long the host can wait.
module dmem_port_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {RspNone, RspCpu, RspHost} rsp_e;

  rsp_e              state_q, state_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_req, host_gnt, cpu_gnt;

  always_comb begin
    cpu_req  = cpu_ren | cpu_wen;
    host_gnt = host_valid & (~cpu_req | (starve_q == StarveMax));
    cpu_gnt  = cpu_req & ~host_gnt;
  end

  assign host_ready = host_gnt;
  assign cpu_stall  = cpu_req & host_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (cpu_gnt) begin
      // A simultaneous read+write from the CPU is treated as a write.
      mem_en    = 1'b1;
      mem_we    = cpu_wen;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (host_gnt || !host_valid) begin
      starve_d = '0;
    end else if (cpu_gnt && host_valid && (starve_q != StarveMax)) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  // Owner of next cycle's mem_rdata; updated every cycle so reads pipeline back to back.
  always_comb begin
    state_d = RspNone;
    if (host_gnt && !host_we) begin
      state_d = RspHost;
    end else if (cpu_gnt && cpu_ren && !cpu_wen) begin
      state_d = RspCpu;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= RspNone;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (state_q == RspCpu) begin
        cpu_rdata_q <= mem_rdata;
      end
    end
  end

  assign host_rvalid = (state_q == RspHost);
  assign host_rdata  = host_rvalid ? mem_rdata : '0;
  // Keep the last CPU read word visible while the pipeline is frozen.
  assign cpu_rdata   = (state_q == RspCpu) ? mem_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios on STARVE_LIMIT=4 and =0 instances,
// then random traffic checked against a transaction-level model with its own memory.
module tb_dmem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          srst, clr;
  logic          cpu_ren, cpu_wen, host_valid, host_we;
  logic [AW-1:0] cpu_addr, host_addr;
  logic [DW-1:0] cpu_wdata, host_wdata;

  logic [DW-1:0] cpu_rdata_w [2];
  logic          cpu_stall_w [2];
  logic          host_ready_w [2];
  logic          host_rvalid_w [2];
  logic [DW-1:0] host_rdata_w [2];
  logic          mem_en_w [2];
  logic          mem_we_w [2];
  logic [AW-1:0] mem_addr_w [2];
  logic [DW-1:0] mem_wdata_w [2];
  logic [DW-1:0] sram_rdata [2];
  logic [DW-1:0] sram [2][1024];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(4)) u0 (
    .clk(clk), .srst(srst), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_w[0]), .cpu_stall(cpu_stall_w[0]),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready_w[0]), .host_rvalid(host_rvalid_w[0]),
    .host_rdata(host_rdata_w[0]), .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]),
    .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]), .mem_rdata(sram_rdata[0])
  );

  dmem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(0)) u1 (
    .clk(clk), .srst(srst), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_w[1]), .cpu_stall(cpu_stall_w[1]),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready_w[1]), .host_rvalid(host_rvalid_w[1]),
    .host_rdata(host_rdata_w[1]), .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]),
    .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]), .mem_rdata(sram_rdata[1])
  );

  // Behavioural single-port SRAMs, one per instance, 1-cycle read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        for (int i = 0; i < 1024; i++) sram[k][i] <= '0;
        sram_rdata[k] <= '0;
      end else if (mem_en_w[k]) begin
        if (mem_we_w[k]) sram[k][mem_addr_w[k]] <= mem_wdata_w[k];
        else             sram_rdata[k] <= sram[k][mem_addr_w[k]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic test_reset();
    set_idle();
    srst = 1'b1; clr = 1'b1;
    tick(); tick();
    #2;
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (cpu_rdata_w[k] !== '0 || host_rvalid_w[k] !== 1'b0 || cpu_stall_w[k] !== 1'b0 ||
          mem_en_w[k] !== 1'b0 || host_ready_w[k] !== 1'b0) begin
        nerr++;
        $display("FAIL reset[%0d] got rdata=%h rvalid=%b stall=%b en=%b rdy=%b exp all 0", k,
                 cpu_rdata_w[k], host_rvalid_w[k], cpu_stall_w[k], mem_en_w[k],
                 host_ready_w[k]);
      end
    end
    tick();
    srst = 1'b0; clr = 1'b0;
  endtask

  task automatic test_cpu_only();
    tick();
    cpu_wen = 1'b1; cpu_addr = 10'd5; cpu_wdata = 32'hA5A5A5A5;
    #2;
    nvec++;
    if (cpu_stall_w[0] !== 1'b0 || mem_we_w[0] !== 1'b1 || mem_en_w[0] !== 1'b1 ||
        mem_addr_w[0] !== 10'd5 || mem_wdata_w[0] !== 32'hA5A5A5A5) begin
      nerr++;
      $display("FAIL cpu_write got stall=%b we=%b en=%b addr=%0d wd=%h exp 0 1 1 5 a5a5a5a5",
               cpu_stall_w[0], mem_we_w[0], mem_en_w[0], mem_addr_w[0], mem_wdata_w[0]);
    end
    tick();
    cpu_wen = 1'b0; cpu_ren = 1'b1;
    #2;
    nvec++;
    if (cpu_stall_w[0] !== 1'b0 || mem_we_w[0] !== 1'b0 || mem_en_w[0] !== 1'b1) begin
      nerr++;
      $display("FAIL cpu_read_issue got stall=%b we=%b en=%b exp 0 0 1",
               cpu_stall_w[0], mem_we_w[0], mem_en_w[0]);
    end
    tick();
    set_idle();
    #2;
    nvec++;
    if (cpu_rdata_w[0] !== 32'hA5A5A5A5) begin
      nerr++;
      $display("FAIL cpu_read_data got %h exp a5a5a5a5", cpu_rdata_w[0]);
    end
  endtask

  task automatic test_host_only();
    tick();
    host_valid = 1'b1; host_we = 1'b1; host_addr = 10'd9; host_wdata = 32'h12345678;
    #2;
    nvec++;
    if (host_ready_w[0] !== 1'b1 || mem_we_w[0] !== 1'b1 || mem_addr_w[0] !== 10'd9) begin
      nerr++;
      $display("FAIL host_write got rdy=%b we=%b addr=%0d exp 1 1 9",
               host_ready_w[0], mem_we_w[0], mem_addr_w[0]);
    end
    tick();
    host_we = 1'b0;
    #2;
    nvec++;
    if (host_ready_w[0] !== 1'b1 || mem_we_w[0] !== 1'b0) begin
      nerr++;
      $display("FAIL host_read_issue got rdy=%b we=%b exp 1 0", host_ready_w[0], mem_we_w[0]);
    end
    tick();
    set_idle();
    #2;
    nvec++;
    if (host_rvalid_w[0] !== 1'b1 || host_rdata_w[0] !== 32'h12345678) begin
      nerr++;
      $display("FAIL host_read_data got rv=%b d=%h exp 1 12345678",
               host_rvalid_w[0], host_rdata_w[0]);
    end
    tick();
    #2;
    nvec++;
    if (host_rvalid_w[0] !== 1'b0 || host_rdata_w[0] !== '0) begin
      nerr++;
      $display("FAIL host_rvalid_drop got rv=%b d=%h exp 0 0", host_rvalid_w[0],
               host_rdata_w[0]);
    end
  endtask

  task automatic test_contention();
    tick();
    cpu_ren = 1'b1; cpu_addr = 10'd0; host_valid = 1'b1; host_we = 1'b0; host_addr = 10'd1;
    for (int i = 0; i < 10; i++) begin
      logic exp_h;
      #2;
      exp_h = ((i % 5) == 4);
      nvec++;
      if (host_ready_w[0] !== exp_h || cpu_stall_w[0] !== exp_h) begin
        nerr++;
        $display("FAIL contention cyc %0d got rdy=%b stall=%b exp %b", i, host_ready_w[0],
                 cpu_stall_w[0], exp_h);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_stall_hold();
    tick();
    cpu_wen = 1'b1; cpu_addr = 10'd3; cpu_wdata = 32'h77;
    tick();
    cpu_wen = 1'b0; cpu_ren = 1'b1;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 10'd9;
    for (int i = 0; i < 5; i++) begin
      #2;
      if (i == 1) begin
        nvec++;
        if (cpu_rdata_w[0] !== 32'h77) begin
          nerr++;
          $display("FAIL hold_first_read got %h exp 77", cpu_rdata_w[0]);
        end
      end
      if (i == 4) begin
        nvec++;
        if (cpu_stall_w[0] !== 1'b1 || host_ready_w[0] !== 1'b1 || cpu_rdata_w[0] !== 32'h77)
        begin
          nerr++;
          $display("FAIL hold_stall_cycle got stall=%b rdy=%b rd=%h exp 1 1 77",
                   cpu_stall_w[0], host_ready_w[0], cpu_rdata_w[0]);
        end
      end
      tick();
    end
    host_valid = 1'b0;
    #2;
    nvec++;
    if (host_rvalid_w[0] !== 1'b1 || host_rdata_w[0] !== 32'h12345678 ||
        cpu_rdata_w[0] !== 32'h77) begin
      nerr++;
      $display("FAIL hold_after_stall got rv=%b hd=%h cd=%h exp 1 12345678 77",
               host_rvalid_w[0], host_rdata_w[0], cpu_rdata_w[0]);
    end
    tick();
    set_idle();
  endtask

  task automatic test_limit0();
    tick();
    cpu_ren = 1'b1; cpu_addr = 10'd0;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 10'd20; host_wdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      #2;
      nvec++;
      if (host_ready_w[1] !== 1'b1 || cpu_stall_w[1] !== 1'b1 || mem_addr_w[1] !== 10'd20 ||
          mem_wdata_w[1] !== host_wdata) begin
        nerr++;
        $display("FAIL limit0 cyc %0d got rdy=%b stall=%b addr=%0d wd=%h exp 1 1 20 %h", i,
                 host_ready_w[1], cpu_stall_w[1], mem_addr_w[1], mem_wdata_w[1], host_wdata);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_read();
    tick();
    cpu_ren = 1'b1; cpu_addr = 10'd3; host_valid = 1'b1; host_we = 1'b0; host_addr = 10'd9;
    for (int i = 0; i < 9; i++) begin
      srst = (i == 3);
      #2;
      if (i == 3) begin
        nvec++;
        if (cpu_stall_w[0] !== 1'b0) begin
          nerr++;
          $display("FAIL rst_comb_grant got stall=%b exp 0", cpu_stall_w[0]);
        end
      end
      if (i == 4) begin
        nvec++;
        if (cpu_rdata_w[0] !== '0 || host_rvalid_w[0] !== 1'b0) begin
          nerr++;
          $display("FAIL rst_clears_rdata got rd=%h rv=%b exp 0 0", cpu_rdata_w[0],
                   host_rvalid_w[0]);
        end
      end
      if (i >= 4) begin
        nvec++;
        if (host_ready_w[0] !== (i == 8)) begin
          nerr++;
          $display("FAIL rst_clears_starve cyc %0d got rdy=%b exp %b", i, host_ready_w[0],
                   (i == 8));
        end
      end
      tick();
    end
    cpu_ren = 1'b0; srst = 1'b1;
    #2;
    nvec++;
    if (host_ready_w[0] !== 1'b1 || host_ready_w[1] !== 1'b1) begin
      nerr++;
      $display("FAIL rst_host_grant got %b %b exp 1 1", host_ready_w[0], host_ready_w[1]);
    end
    tick();
    srst = 1'b0;
    set_idle();
    #2;
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (host_rvalid_w[k] !== 1'b0 || cpu_rdata_w[k] !== '0) begin
        nerr++;
        $display("FAIL rst_no_rvalid[%0d] got rv=%b rd=%h exp 0 0", k, host_rvalid_w[k],
                 cpu_rdata_w[k]);
      end
    end
  endtask

  // Random traffic against a model: a memory array, a pending-read record
  // (owner and word) and a count of CPU wins while the host waits.
  task automatic test_random();
    logic [DW-1:0] ref_mem [2][1024];
    int            wins [2];
    int            pown [2];
    logic [DW-1:0] pdat [2];
    logic [DW-1:0] hold [2];
    logic          acc0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) ref_mem[k][i] = '0;
      wins[k] = 0; pown[k] = 0; pdat[k] = '0; hold[k] = '0;
    end
    tick();
    set_idle();
    srst = 1'b1; clr = 1'b1;
    tick();
    srst = 1'b0; clr = 1'b0;
    acc0 = 1'b1;
    for (int n = 0; n < 600; n++) begin
      srst      = ($urandom_range(39) == 0);
      cpu_ren   = 1'($urandom_range(1));
      cpu_wen   = ($urandom_range(2) == 0);
      cpu_addr  = AW'($urandom_range(15));
      cpu_wdata = $urandom;
      if (!(host_valid && !acc0 && $urandom_range(9) != 0)) begin
        host_valid = ($urandom_range(9) < 6);
        host_we    = 1'($urandom_range(1));
        host_addr  = AW'($urandom_range(15));
        host_wdata = $urandom;
      end
      #2;
      for (int k = 0; k < 2; k++) begin
        int            lim;
        logic          creq, hg, cg, e_en, e_we, e_rv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_hrd, e_crd;
        lim  = (k == 0) ? 4 : 0;
        creq = cpu_ren | cpu_wen;
        hg   = host_valid && (!creq || wins[k] == lim);
        cg   = creq && !hg;
        e_en = hg | cg;
        e_we   = hg ? host_we   : (cg ? cpu_wen   : 1'b0);
        e_addr = hg ? host_addr : (cg ? cpu_addr  : '0);
        e_wd   = hg ? host_wdata : (cg ? cpu_wdata : '0);
        e_rv   = (pown[k] == 2);
        e_hrd  = e_rv ? pdat[k] : '0;
        e_crd  = (pown[k] == 1) ? pdat[k] : hold[k];
        if (k == 0) acc0 = hg;
        nvec++;
        if (host_ready_w[k] !== hg || cpu_stall_w[k] !== (creq && hg)) begin
          nerr++;
          $display("FAIL rnd_grant[%0d] n=%0d got rdy=%b stall=%b exp %b %b", k, n,
                   host_ready_w[k], cpu_stall_w[k], hg, creq && hg);
        end
        nvec++;
        if (mem_en_w[k] !== e_en || mem_we_w[k] !== e_we || mem_addr_w[k] !== e_addr ||
            mem_wdata_w[k] !== e_wd) begin
          nerr++;
          $display("FAIL rnd_mem[%0d] n=%0d got %b %b %h %h exp %b %b %h %h", k, n,
                   mem_en_w[k], mem_we_w[k], mem_addr_w[k], mem_wdata_w[k],
                   e_en, e_we, e_addr, e_wd);
        end
        nvec++;
        if (host_rvalid_w[k] !== e_rv || host_rdata_w[k] !== e_hrd) begin
          nerr++;
          $display("FAIL rnd_host_rsp[%0d] n=%0d got %b %h exp %b %h", k, n,
                   host_rvalid_w[k], host_rdata_w[k], e_rv, e_hrd);
        end
        nvec++;
        if (cpu_rdata_w[k] !== e_crd) begin
          nerr++;
          $display("FAIL rnd_cpu_rdata[%0d] n=%0d got %h exp %h", k, n, cpu_rdata_w[k], e_crd);
        end
        // Advance the model by one clock.
        hold[k] = (pown[k] == 1) ? pdat[k] : hold[k];
        if (hg && !host_we) begin
          pown[k] = 2; pdat[k] = ref_mem[k][host_addr];
        end else if (cg && cpu_ren && !cpu_wen) begin
          pown[k] = 1; pdat[k] = ref_mem[k][cpu_addr];
        end else begin
          pown[k] = 0;
        end
        if (e_en && e_we) ref_mem[k][e_addr] = e_wd;
        if (hg || !host_valid) wins[k] = 0;
        else if (cg && wins[k] < lim) wins[k] = wins[k] + 1;
        if (srst) begin
          pown[k] = 0; wins[k] = 0; hold[k] = '0;
        end
      end
      tick();
    end
    srst = 1'b0;
    set_idle();
  endtask

  initial begin
    srst = 1'b1;
    clr  = 1'b1;
    set_idle();
    test_reset();
    test_cpu_only();
    test_host_only();
    test_contention();
    test_stall_hold();
    test_limit0();
    tick();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port data memory SRAM between the CPU MEM stage and the external host port. The CPU has default priority. A starvation counter guarantees the host a slot after a bounded number of CPU wins. When the CPU loses arbitration, the block raises a stall that freezes the pipeline enables. Read data (1-cycle SRAM latency) is routed back to whichever requester owns the outstanding read.

Parameters:
DATA_W, 32, data word width
ADDR_W, 10, memory address width
STARVE_LIMIT, 4, maximum consecutive CPU grants while host waits (0 = host strict priority)

Ports:
clk  input  1  clock; all state updates on its rising edge
srst  input  1  reset; one clock, reset is synchronous and active-high
cpu_ren  input  1  CPU MEM-stage read request
cpu_wen  input  1  CPU MEM-stage write request
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  DATA_W  CPU write data
cpu_rdata  output  DATA_W  CPU read data
cpu_stall  output  1  CPU request not granted this cycle; hold pipeline
host_valid  input  1  host request valid
host_we  input  1  host request is write
host_addr  input  ADDR_W  host address
host_wdata  input  DATA_W  host write data
host_ready  output  1  host request accepted this cycle
host_rvalid  output  1  host read data valid
host_rdata  output  DATA_W  host read data
mem_en  output  1  SRAM access enable
mem_we  output  1  SRAM write enable
mem_addr  output  ADDR_W  SRAM address
mem_wdata  output  DATA_W  SRAM write data
mem_rdata  input  DATA_W  SRAM read data, valid 1 cycle after read issue

Behaviour:
- cpu_req = cpu_ren | cpu_wen. If both are set: write, no read response.
- Grant is combinational each cycle:
  - host_gnt = host_valid & (!cpu_req | starve_cnt == STARVE_LIMIT).
  - cpu_gnt = cpu_req & !host_gnt.
- Outputs from grant:
  - host_ready = host_gnt.
  - cpu_stall = cpu_req & host_gnt.
  - A request is accepted in the cycle its grant is high. The host must hold its fields stable until host_ready.
- SRAM drive:
  - mem_en = host_gnt | cpu_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted requester.
  - When there is no grant, all SRAM drive outputs are 0.
- starve_cnt (width clog2(STARVE_LIMIT+1), minimum 1 bit), checked in this order:
  - host_gnt or !host_valid: clear to 0.
  - Otherwise, cpu_gnt & host_valid: increment, saturating at STARVE_LIMIT.
- Read-owner FSM, registered, tracks who owns next cycle's mem_rdata. States: RSP_NONE, RSP_CPU, RSP_HOST.
  - Next state = RSP_HOST if host read granted.
  - Else RSP_CPU if CPU read granted (cpu_ren & !cpu_wen).
  - Else RSP_NONE.
  - Transitions occur every cycle regardless of the current state; back-to-back reads are fully pipelined.
- Host read response:
  - host_rvalid = (state == RSP_HOST).
  - host_rdata = mem_rdata when host_rvalid, else 0.
- CPU read response:
  - cpu_rdata_q captures mem_rdata in state RSP_CPU.
  - cpu_rdata = mem_rdata in RSP_CPU, else cpu_rdata_q, so data holds stable while the CPU is stalled later.
- Latency:
  - Write: takes effect in the grant cycle.
  - Read: data appears exactly 1 cycle after the grant.
  - Host: no more than STARVE_LIMIT+1 cycles from host_valid to host_ready under continuous CPU traffic.
- STARVE_LIMIT=0: host wins every conflict; CPU stalls whenever host_valid.
- Reset: srst forces state=RSP_NONE, starve_cnt=0 and cpu_rdata_q=0. Combinational outputs still follow inputs during reset.
- A read issued in the same cycle srst is asserted produces no rvalid in the following cycle.
- A host that drops host_valid before acceptance is legal; the counter clears.

Test Plan:
- CPU only:
  - Stimulus: cpu_wen addr 5 data 0xA5A5A5A5; next cycle cpu_ren addr 5.
  - Required: no stall; mem_we=1 in the write cycle; cpu_rdata=0xA5A5A5A5 one cycle after the read.
- Host only:
  - Stimulus: host write addr 9 data 0x12345678, then host read addr 9.
  - Required: host_ready=1 immediately for each; host_rvalid=1 with host_rdata=0x12345678 one cycle after the read grant.
- Contention (STARVE_LIMIT=4):
  - Stimulus: continuous cpu_ren plus host_valid.
  - Required: CPU granted 4 cycles; 5th cycle host_ready=1 and cpu_stall=1; the counter returns to 0 and the pattern repeats every 5 cycles.
- Stalled CPU read hold:
  - Stimulus: CPU reads addr 3 (=0x77); next cycle host wins.
  - Required: cpu_rdata stays 0x77 through the stall cycle while host_rvalid is routed separately.
- STARVE_LIMIT=0:
  - Stimulus: simultaneous requests for 3 cycles.
  - Required: host_ready=1 and cpu_stall=1 all 3 cycles.
- Reset mid-read:
  - Stimulus: host read granted in the cycle srst=1.
  - Required: host_rvalid=0 next cycle; starve_cnt=0; cpu_rdata=0.
